rtc_access_scheduler: RTL and testbench
=======================================

Name: rtc_access_scheduler

Overview:
- Sequences every access to the RTC parallel-bus transaction engine (the block driving AD/CS/RD/WR) and shares it between two requesters:
  - PicoBlaze command port: single reads/writes decoded from port_id/strobes upstream.
  - Internal periodic refresh sweep: reads the clock, date and timer registers and pushes them into the VGA register bank.
- Arbitrates per transaction and keeps the engine handshake strictly one-outstanding.

Parameters:
- REFRESH_CYCLES, 5000000, clk cycles between sweep starts (counter width 32).
- NUM_REGS, 9, sweep length; addresses come from a fixed table, indices 0..8 = 0x21,0x22,0x23,0x24,0x25,0x26,0x41,0x42,0x43.
- TIMEOUT_CYCLES, 1023, engine watchdog limit (only used with RTC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_req  in  1  level; PicoBlaze command pending, held until cmd_ack.
- cmd_wr  in  1  1=write, 0=read; stable while cmd_req is high.
- cmd_addr  in  8  RTC register address.
- cmd_wdata  in  8  write data.
- cmd_ack  out  1  1-cycle pulse; command granted.
- cmd_done  out  1  1-cycle pulse; command finished.
- cmd_rdata  out  8  read result; valid from cmd_done, held until the next cmd_done.
- eng_start  out  1  1-cycle pulse; start one engine transaction.
- eng_wr  out  1  transaction direction.
- eng_addr  out  8  transaction address.
- eng_wdata  out  8  transaction write data.
- eng_done  in  1  1-cycle pulse from engine.
- eng_rdata  in  8  engine read data, valid with eng_done.
- upd_valid  out  1  1-cycle pulse; sweep result available.
- upd_index  out  4  register index 0..NUM_REGS-1.
- upd_data  out  8  sweep read data.
- sweep_busy  out  1  high from sweep start until its last transaction completes.
- err_timeout  out  1  sticky watchdog error.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (reset=0 at a clk edge) clears all outputs to 0: refresh counter, sweep index and sweep pending, last_grant=SWEEP, FSM=IDLE.
- Reset mid-transaction abandons the transaction and the sweep. The engine shares the same reset.
- Refresh counter: counts 0..REFRESH_CYCLES-1 and wraps. On reaching the terminal count, sweep_pend is set if no sweep is active; otherwise that tick is dropped (no queueing).
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE, arbitration:
  - Only cmd_req pending: select CMD.
  - Only sweep pending/active: select SWEEP.
  - Both: select opposite of last_grant. After reset this gives CMD first.
  - Arbitration happens only between transactions; an engine transaction is never preempted.
- IDLE -> ISSUE on any selection. Sweep start raises sweep_busy and sets index to 0.
- ISSUE (1 cycle):
  - eng_start=1; eng_wr/eng_addr/eng_wdata loaded.
  - For CMD: from cmd_* and cmd_ack=1 in the same cycle.
  - For SWEEP: eng_wr=0, eng_addr=table[index].
  - eng_* stay stable until eng_done. -> WAIT.
- WAIT: hold until eng_done=1, capture eng_rdata -> FINISH.
- FINISH (1 cycle), then -> IDLE and last_grant updated:
  - CMD: cmd_done=1, cmd_rdata=captured data (for writes, cmd_rdata=0x00).
  - SWEEP: upd_valid=1, upd_index=index, upd_data=captured data. If index==NUM_REGS-1, sweep_busy and sweep_pend clear; else index+1.
- Latency, idle engine with 1-cycle engine: cmd_req high at cycle N -> cmd_ack/eng_start at N+1 -> cmd_done one cycle after eng_done.
- eng_done outside WAIT is ignored.
- err_clr clears err_timeout. If a new timeout occurs in the same cycle, set wins.

Optional Feature:
- Macro: RTC_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles; at TIMEOUT_CYCLES without eng_done it sets err_timeout and proceeds to FINISH.
  - CMD: cmd_done pulses with cmd_rdata=0xFF.
  - SWEEP: upd_valid is suppressed but the index still advances.
- Not defined: WAIT waits indefinitely; err_timeout is tied to 0; err_clr is ignored.

Test Plan:
- Reset, then idle with REFRESH_CYCLES=100 -> at cycle 100 the sweep runs. With a 3-cycle engine model: nine upd_valid pulses, indices 0..8, addresses 0x21..0x26,0x41..0x43, upd_data equal to model contents. sweep_busy falls after index 8.
- cmd_req read addr 0x22 while idle, engine returns 0x59 -> cmd_ack and eng_start in the cycle after cmd_req; cmd_done with cmd_rdata=0x59. No upd_valid.
- cmd_req (write 0x23, data 0x12) raised during sweep index 2 -> index 2 completes, then the command is issued, then sweep index 3. Model register 0x23=0x12 and the subsequent sweep index 2 reads 0x12.
- Command and sweep tick in the same cycle after reset -> command granted first, then sweep index 0.
- Reset asserted while in WAIT -> next cycle all outputs 0, sweep_busy=0. The next sweep restarts at index 0.
- RTC_TIMEOUT_EN, TIMEOUT_CYCLES=20, engine never responds to a read cmd -> cmd_done after 20 WAIT cycles with cmd_rdata=0xFF, err_timeout=1 until err_clr pulse.

Source files
------------

// File: rtl/rtc_access_scheduler.sv
// Shares the RTC bus transaction engine between PicoBlaze commands and a periodic refresh sweep.
// Optional engine watchdog: define RTC_TIMEOUT_EN.
module rtc_access_scheduler #(
  parameter int REFRESH_CYCLES = 5000000,
  parameter int NUM_REGS       = 9,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_ack,
  output logic       cmd_done,
  output logic [7:0] cmd_rdata,
  output logic       eng_start,
  output logic       eng_wr,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_wdata,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic       upd_valid,
  output logic [3:0] upd_index,
  output logic [7:0] upd_data,
  output logic       sweep_busy,
  output logic       err_timeout,
  input  logic       err_clr,
  output logic [1:0] dbg_state
);

  // Handshakes: cmd_req is a level held until the one-cycle cmd_ack; the engine gets one
  // eng_start pulse per transaction with eng_* held until its eng_done pulse (one outstanding).
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, FINISH = 2'd3} state_t;
  typedef enum logic {OWN_CMD = 1'b0, OWN_SWEEP = 1'b1} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d, last_grant_q, last_grant_d;
  logic [31:0] refresh_cnt_q, refresh_cnt_d;
  logic        sweep_pend_q, sweep_pend_d, sweep_busy_q, sweep_busy_d;
  logic [3:0]  sweep_idx_q, sweep_idx_d;
  logic        cmd_ack_q, cmd_ack_d, cmd_done_q, cmd_done_d;
  logic [7:0]  cmd_rdata_q, cmd_rdata_d;
  logic        eng_start_q, eng_start_d, eng_wr_q, eng_wr_d;
  logic [7:0]  eng_addr_q, eng_addr_d, eng_wdata_q, eng_wdata_d;
  logic        upd_valid_q, upd_valid_d;
  logic [3:0]  upd_index_q, upd_index_d;
  logic [7:0]  upd_data_q, upd_data_d;
  logic        finish_now, timed_out, refresh_tick;
`ifdef RTC_TIMEOUT_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
`endif

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h43;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    refresh_tick  = (refresh_cnt_q == 32'(REFRESH_CYCLES - 1));
    refresh_cnt_d = refresh_tick ? 32'd0 : refresh_cnt_q + 32'd1;
    // A tick while a sweep is pending or running is simply absorbed.
    sweep_pend_d  = sweep_pend_q | refresh_tick;
    sweep_busy_d  = sweep_busy_q;
    sweep_idx_d   = sweep_idx_q;
    cmd_ack_d     = 1'b0;
    cmd_done_d    = 1'b0;
    cmd_rdata_d   = cmd_rdata_q;
    eng_start_d   = 1'b0;
    eng_wr_d      = eng_wr_q;
    eng_addr_d    = eng_addr_q;
    eng_wdata_d   = eng_wdata_q;
    upd_valid_d   = 1'b0;
    upd_index_d   = upd_index_q;
    upd_data_d    = upd_data_q;
    finish_now    = 1'b0;
    timed_out     = 1'b0;
`ifdef RTC_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q & ~err_clr;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_req && (!sweep_pend_q || last_grant_q == OWN_SWEEP)) begin
          owner_d     = OWN_CMD;
          state_d     = ISSUE;
          cmd_ack_d   = 1'b1;
          eng_start_d = 1'b1;
          eng_wr_d    = cmd_wr;
          eng_addr_d  = cmd_addr;
          eng_wdata_d = cmd_wdata;
        end else if (sweep_pend_q) begin
          owner_d      = OWN_SWEEP;
          state_d      = ISSUE;
          eng_start_d  = 1'b1;
          eng_wr_d     = 1'b0;
          eng_wdata_d  = 8'h00;
          sweep_busy_d = 1'b1;
          if (!sweep_busy_q) sweep_idx_d = 4'd0;
          eng_addr_d   = reg_addr(sweep_busy_q ? sweep_idx_q : 4'd0);
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef RTC_TIMEOUT_EN
        wait_cnt_d = 32'd0;
`endif
      end
      WAIT: begin
        if (eng_done) finish_now = 1'b1;
`ifdef RTC_TIMEOUT_EN
        else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          finish_now = 1'b1;
          timed_out  = 1'b1;
        end else wait_cnt_d = wait_cnt_q + 32'd1;
`endif
        if (finish_now) begin
          state_d = FINISH;
          if (owner_q == OWN_CMD) begin
            cmd_done_d  = 1'b1;
            cmd_rdata_d = timed_out ? 8'hFF : (eng_wr_q ? 8'h00 : eng_rdata);
          end else if (!timed_out) begin
            upd_valid_d = 1'b1;
            upd_index_d = sweep_idx_q;
            upd_data_d  = eng_rdata;
          end
        end
      end
      FINISH: begin
        state_d      = IDLE;
        last_grant_d = owner_q;
        if (owner_q == OWN_SWEEP) begin
          if (sweep_idx_q == 4'(NUM_REGS - 1)) begin
            sweep_busy_d = 1'b0;
            sweep_pend_d = 1'b0;
            sweep_idx_d  = 4'd0;
          end else sweep_idx_d = sweep_idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef RTC_TIMEOUT_EN
    if (timed_out) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_CMD;
      last_grant_q  <= OWN_SWEEP;
      refresh_cnt_q <= 32'd0;
      sweep_pend_q  <= 1'b0;
      sweep_busy_q  <= 1'b0;
      sweep_idx_q   <= 4'd0;
      cmd_ack_q     <= 1'b0;
      cmd_done_q    <= 1'b0;
      cmd_rdata_q   <= 8'h00;
      eng_start_q   <= 1'b0;
      eng_wr_q      <= 1'b0;
      eng_addr_q    <= 8'h00;
      eng_wdata_q   <= 8'h00;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= 4'd0;
      upd_data_q    <= 8'h00;
`ifdef RTC_TIMEOUT_EN
      wait_cnt_q    <= 32'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      refresh_cnt_q <= refresh_cnt_d;
      sweep_pend_q  <= sweep_pend_d;
      sweep_busy_q  <= sweep_busy_d;
      sweep_idx_q   <= sweep_idx_d;
      cmd_ack_q     <= cmd_ack_d;
      cmd_done_q    <= cmd_done_d;
      cmd_rdata_q   <= cmd_rdata_d;
      eng_start_q   <= eng_start_d;
      eng_wr_q      <= eng_wr_d;
      eng_addr_q    <= eng_addr_d;
      eng_wdata_q   <= eng_wdata_d;
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_data_q    <= upd_data_d;
`ifdef RTC_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign cmd_ack    = cmd_ack_q;
  assign cmd_done   = cmd_done_q;
  assign cmd_rdata  = cmd_rdata_q;
  assign eng_start  = eng_start_q;
  assign eng_wr     = eng_wr_q;
  assign eng_addr   = eng_addr_q;
  assign eng_wdata  = eng_wdata_q;
  assign upd_valid  = upd_valid_q;
  assign upd_index  = upd_index_q;
  assign upd_data   = upd_data_q;
  assign sweep_busy = sweep_busy_q;
  assign dbg_state  = state_q;
`ifdef RTC_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: behavioural RTC register model behind an engine model,
// monitor queues of bus events, and per-scenario tasks comparing against expected sequences.
module tb_rtc_access_scheduler;
  localparam int REFRESH = 100;
  localparam int NREG    = 9;
  localparam int TMO     = 20;
  localparam logic [7:0] SWEEP_ADDR [NREG] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_req = 1'b0, cmd_wr = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic       cmd_ack, cmd_done, eng_start, eng_wr, upd_valid, sweep_busy, err_timeout;
  logic [7:0] cmd_rdata, eng_addr, eng_wdata, upd_data;
  logic [3:0] upd_index;
  logic [1:0] dbg_state;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rdata = 8'h00;
  logic       err_clr = 1'b0;

  rtc_access_scheduler #(.REFRESH_CYCLES(REFRESH), .NUM_REGS(NREG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdata(eng_rdata), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_data(upd_data), .sweep_busy(sweep_busy), .err_timeout(err_timeout), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rel_cyc = 0;

  // RTC device model behind the engine
  logic [7:0] rtc_mem [256];
  int  eng_lat  = 3;
  bit  eng_rand = 1'b0;
  bit  eng_mute = 1'b0;

  initial begin
    logic [7:0] a, d;
    logic       w;
    bit         abort;
    int         lat;
    forever begin
      @(posedge clk); #1;
      if (reset && eng_start && !eng_mute) begin
        a = eng_addr; w = eng_wr; d = eng_wdata; abort = 1'b0;
        lat = eng_rand ? int'($urandom_range(1, 4)) : eng_lat;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (!reset) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          eng_done  = 1'b1;
          eng_rdata = w ? 8'($urandom) : rtc_mem[a];
          if (w) rtc_mem[a] = d;
          @(posedge clk); #1;
          eng_done  = 1'b0;
          eng_rdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: bus events with the edge count after which they became visible
  logic [16:0] eng_log[$];
  int          eng_cyc[$];
  logic [11:0] upd_log[$];
  int          upd_cyc[$];
  logic [7:0]  done_log[$];
  int          done_cyc[$];
  int          engdone_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      if (eng_start) begin eng_log.push_back({eng_wr, eng_addr, eng_wdata}); eng_cyc.push_back(cyc); end
      if (upd_valid) begin upd_log.push_back({upd_index, upd_data}); upd_cyc.push_back(cyc); end
      if (cmd_done)  begin done_log.push_back(cmd_rdata); done_cyc.push_back(cyc); end
      if (eng_done)  engdone_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    cmd_req = 1'b0; err_clr = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    eng_log.delete(); eng_cyc.delete(); upd_log.delete(); upd_cyc.delete();
    done_log.delete(); done_cyc.delete(); engdone_cyc.delete();
    reset = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd, output bit acked);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_req = 1'b1; acked = 1'b0;
    for (int i = 0; i < 300 && !acked; i++) begin
      tick();
      if (cmd_ack) acked = 1'b1;
    end
    cmd_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output logic [7:0] rd);
    ok = 1'b0; rd = 8'h00;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (cmd_done) begin ok = 1'b1; rd = cmd_rdata; end
    end
  endtask

  task automatic wait_upd(input int n, input int budget);
    for (int i = 0; i < budget && upd_log.size() < n; i++) tick();
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    tick();
    checks++; if ({cmd_ack, cmd_done, eng_start, upd_valid} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b expected 0000", {cmd_ack, cmd_done, eng_start, upd_valid}); end
    checks++; if (cmd_rdata !== 8'h00) begin errors++; $display("FAIL reset_cmd_rdata got %h expected 00", cmd_rdata); end
    checks++; if ({eng_wr, eng_addr, eng_wdata} !== 17'h0) begin errors++; $display("FAIL reset_eng_bus got %h expected 0", {eng_wr, eng_addr, eng_wdata}); end
    checks++; if ({upd_index, upd_data} !== 12'h0) begin errors++; $display("FAIL reset_upd got %h expected 000", {upd_index, upd_data}); end
    checks++; if (sweep_busy !== 1'b0) begin errors++; $display("FAIL reset_sweep_busy got %b expected 0", sweep_busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err_timeout); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", dbg_state); end
  endtask

  task automatic test_sweep();
    bit busy_checked = 1'b0;
    int start_dist;
    do_reset();
    for (int i = 0; i < REFRESH + 200 && upd_log.size() < NREG; i++) begin
      tick();
      if (!busy_checked && eng_log.size() == 1) begin
        busy_checked = 1'b1;
        checks++; if (sweep_busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_rise got %b expected 1", sweep_busy); end
      end
    end
    checks++; if (upd_log.size() != NREG) begin errors++; $display("FAIL sweep_count got %0d expected %0d", upd_log.size(), NREG); end
    if (eng_cyc.size() > 0) begin
      start_dist = eng_cyc[0] - rel_cyc;
      checks++; if (start_dist < REFRESH || start_dist > REFRESH + 2) begin errors++; $display("FAIL sweep_start_time got %0d expected %0d..%0d", start_dist, REFRESH, REFRESH + 2); end
    end
    for (int i = 0; i < NREG && i < upd_log.size() && i < eng_log.size(); i++) begin
      checks++; if (eng_log[i][16:8] !== {1'b0, SWEEP_ADDR[i]}) begin errors++; $display("FAIL sweep_addr[%0d] got %h expected %h", i, eng_log[i][16:8], {1'b0, SWEEP_ADDR[i]}); end
      checks++; if (upd_log[i] !== {4'(i), rtc_mem[SWEEP_ADDR[i]]}) begin errors++; $display("FAIL sweep_upd[%0d] got %h expected %h", i, upd_log[i], {4'(i), rtc_mem[SWEEP_ADDR[i]]}); end
    end
    tick(); tick();
    checks++; if (sweep_busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_fall got %b expected 0", sweep_busy); end
  endtask

  task automatic test_cmd_read();
    bit ok;
    logic [7:0] rd;
    do_reset();
    rtc_mem[8'h22] = 8'h59;
    tick();
    cmd_wr = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'hA5; cmd_req = 1'b1;
    tick();
    checks++; if ({cmd_ack, eng_start} !== 2'b11) begin errors++; $display("FAIL cmd_ack_latency got %b expected 11", {cmd_ack, eng_start}); end
    checks++; if ({eng_wr, eng_addr} !== 9'h022) begin errors++; $display("FAIL cmd_eng_addr got %h expected 022", {eng_wr, eng_addr}); end
    cmd_req = 1'b0;
    wait_done(ok, rd);
    checks++; if (!ok || rd !== 8'h59) begin errors++; $display("FAIL cmd_read_data got %h (done=%0d) expected 59", rd, ok); end
    if (done_cyc.size() > 0 && engdone_cyc.size() > 0) begin
      checks++; if (done_cyc[0] != engdone_cyc[0] + 1) begin errors++; $display("FAIL cmd_done_latency got %0d expected %0d", done_cyc[0], engdone_cyc[0] + 1); end
    end
    checks++; if (upd_log.size() != 0) begin errors++; $display("FAIL cmd_no_upd got %0d expected 0", upd_log.size()); end
  endtask

  task automatic test_cmd_during_sweep();
    logic [16:0] exp_q[$];
    logic [16:0] obs;
    logic [7:0]  old23, rd;
    bit          ok;
    do_reset();
    old23 = rtc_mem[8'h23];
    for (int i = 0; i < REFRESH + 100 && eng_log.size() < 3; i++) tick();
    send_cmd(1'b1, 8'h23, 8'h12, ok);
    wait_done(ok, rd);
    checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL mid_write_rdata got %h (done=%0d) expected 00", rd, ok); end
    wait_upd(NREG, 200);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, SWEEP_ADDR[i], 8'h00});
    exp_q.push_back({1'b1, 8'h23, 8'h12});
    for (int i = 3; i < NREG; i++) exp_q.push_back({1'b0, SWEEP_ADDR[i], 8'h00});
    checks++; if (eng_log.size() < exp_q.size()) begin errors++; $display("FAIL mid_eng_count got %0d expected %0d", eng_log.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < eng_log.size(); k++) begin
      obs = eng_log[k];
      if (!exp_q[k][16]) obs[7:0] = 8'h00;
      checks++; if (obs !== exp_q[k]) begin errors++; $display("FAIL mid_order[%0d] got %h expected %h", k, obs, exp_q[k]); end
    end
    if (upd_log.size() > 2) begin
      checks++; if (upd_log[2] !== {4'd2, old23}) begin errors++; $display("FAIL mid_idx2_old got %h expected %h", upd_log[2], {4'd2, old23}); end
    end
    wait_upd(2 * NREG, 400);
    checks++; if (upd_log.size() < NREG + 3) begin errors++; $display("FAIL second_sweep_count got %0d expected >=%0d", upd_log.size(), NREG + 3); end
    else begin
      checks++; if (upd_log[NREG + 2] !== {4'd2, 8'h12}) begin errors++; $display("FAIL second_sweep_idx2 got %h expected 212", upd_log[NREG + 2]); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [7:0] rd, a;
    do_reset();
    a = 8'h30 + 8'($urandom_range(0, 15));
    repeat (REFRESH) tick();
    cmd_wr = 1'b0; cmd_addr = a; cmd_req = 1'b1;
    tick();
    checks++; if ({cmd_ack, eng_start, eng_addr} !== {2'b11, a}) begin errors++; $display("FAIL tie_cmd_first got %h expected %h", {cmd_ack, eng_start, eng_addr}, {2'b11, a}); end
    cmd_req = 1'b0;
    wait_done(ok, rd);
    checks++; if (!ok || rd !== rtc_mem[a]) begin errors++; $display("FAIL tie_cmd_data got %h expected %h", rd, rtc_mem[a]); end
    wait_upd(1, 100);
    checks++; if (eng_log.size() < 2) begin errors++; $display("FAIL tie_eng_count got %0d expected >=2", eng_log.size()); end
    else begin
      checks++; if (eng_log[1][16:8] !== 9'h021) begin errors++; $display("FAIL tie_sweep_second got %h expected 021", eng_log[1][16:8]); end
    end
    if (upd_log.size() > 0) begin
      checks++; if (upd_log[0][11:8] !== 4'd0) begin errors++; $display("FAIL tie_first_idx got %0d expected 0", upd_log[0][11:8]); end
    end
    wait_upd(NREG, 200);
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    eng_lat = 6;
    for (int i = 0; i < REFRESH + 100 && eng_log.size() < 4; i++) tick();
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if ({cmd_ack, cmd_done, eng_start, upd_valid, sweep_busy} !== 5'b0) begin errors++; $display("FAIL rstw_flags got %b expected 00000", {cmd_ack, cmd_done, eng_start, upd_valid, sweep_busy}); end
    checks++; if ({upd_index, upd_data, eng_addr} !== 20'h0) begin errors++; $display("FAIL rstw_data got %h expected 0", {upd_index, upd_data, eng_addr}); end
    eng_lat = 3;
    do_reset();
    wait_upd(1, REFRESH + 100);
    checks++; if (upd_log.size() < 1 || upd_log[0][11:8] !== 4'd0) begin errors++; $display("FAIL rstw_restart_idx got %0d entries expected index 0", upd_log.size()); end
    if (eng_log.size() > 0) begin
      checks++; if (eng_log[0][15:8] !== 8'h21) begin errors++; $display("FAIL rstw_restart_addr got %h expected 21", eng_log[0][15:8]); end
    end
    wait_upd(NREG, 200);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] shadow [256];
    logic [7:0] a, d, rd, e;
    logic       w;
    bit         ok;
    do_reset();
    eng_rand = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = rtc_mem[i];
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 8)) tick();
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (w) a = 8'h30 + 8'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 1) a = SWEEP_ADDR[$urandom_range(0, NREG - 1)];
      else a = 8'h30 + 8'($urandom_range(0, 15));
      exp_q.push_back(w ? 8'h00 : shadow[a]);
      send_cmd(w, a, d, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_ack[%0d] got none expected ack", n); end
      wait_done(ok, rd);
      e = exp_q.pop_front();
      checks++; if (!ok || rd !== e) begin errors++; $display("FAIL rand_rdata[%0d] got %h (done=%0d) expected %h", n, rd, ok, e); end
      if (w) shadow[a] = d;
    end
    eng_rand = 1'b0;
    checks++; if (upd_log.size() < NREG) begin errors++; $display("FAIL rand_sweeps got %0d expected >=%0d", upd_log.size(), NREG); end
    for (int k = 0; k < upd_log.size(); k++) begin
      checks++; if (upd_log[k] !== {4'(k % NREG), shadow[SWEEP_ADDR[k % NREG]]}) begin errors++; $display("FAIL rand_upd[%0d] got %h expected %h", k, upd_log[k], {4'(k % NREG), shadow[SWEEP_ADDR[k % NREG]]}); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] rd;
    do_reset();
`ifdef RTC_TIMEOUT_EN
    eng_mute = 1'b1;
    send_cmd(1'b0, 8'h31, 8'h00, ok);
    wait_done(ok, rd);
    checks++; if (!ok || rd !== 8'hFF) begin errors++; $display("FAIL tmo_rdata got %h (done=%0d) expected ff", rd, ok); end
    if (done_cyc.size() > 0 && eng_cyc.size() > 0) begin
      checks++; if (done_cyc[0] - eng_cyc[0] != TMO + 1) begin errors++; $display("FAIL tmo_latency got %0d expected %0d", done_cyc[0] - eng_cyc[0], TMO + 1); end
    end
    eng_mute = 1'b0;
    repeat (3) tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b expected 1", err_timeout); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b expected 0", err_timeout); end
`else
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL err_tied got %b expected 0", err_timeout); end
    ok = 1'b0; rd = 8'h00;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'($urandom);
    test_reset();
    test_sweep();
    test_cmd_read();
    test_cmd_during_sweep();
    test_simultaneous();
    test_reset_in_wait();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
